// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle FETCH/EXEC/HALT control for the single-issue core.
// Owns the architectural PC, presents each fetched instruction for exactly one
// EXEC cycle, gates the register-file write and parks the core on ebreak or on
// a misaligned jump target.
// Optional feature macro: SEQ_PERF_CNT_EN (mcycle/minstret performance counters).
module exec_sequencer (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  input  logic        stop,
  input  logic        rf_wen_req,
  output logic        rf_wen,
  output logic        halted,
  output logic        halt_err,
  output logic [63:0] mcycle,
  output logic [63:0] minstret
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 64;

  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] INST_INC = 32'h0000_0004;

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EXEC  = 2'b01,
    S_HALT  = 2'b10
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nxt;
  logic            capture;
  logic            misaligned;
  logic            err_set;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, PC update and per-state control outputs
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    rf_wen     = 1'b0;
    capture    = 1'b0;
    misaligned = 1'b0;
    err_set    = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_rvalid) begin
          capture   = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        inst_valid = 1'b1;
        misaligned = jump && (jump_addr[1:0] != 2'b00);
        rf_wen     = rf_wen_req && !misaligned;
        if (stop) begin
          // ebreak wins over a simultaneous bad target: clean halt
          state_nxt = S_HALT;
        end else if (misaligned) begin
          state_nxt = S_HALT;
          err_set   = 1'b1;
        end else begin
          pc_nxt    = jump ? jump_addr : XLEN'(pc + INST_INC);
          state_nxt = S_FETCH;
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  // Fetch address is the architectural PC itself
  assign imem_addr = pc;

  // Architectural PC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_nxt;
    end
  end

  // Instruction capture on the accepted fetch response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst    <= NOP_INST;
      inst_pc <= RESET_PC;
    end else if (capture) begin
      inst    <= imem_rdata;
      inst_pc <= pc;
    end
  end

  // Halt status flags, visible the cycle after the causing EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted   <= 1'b0;
      halt_err <= 1'b0;
    end else begin
      halted   <= (state_nxt == S_HALT);
      halt_err <= halt_err || err_set;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] mcycle_q;
  logic [CNT_W-1:0] minstret_q;
  logic             retire;

  // An EXEC retires unless it is the misaligned-jump exit
  assign retire = (state == S_EXEC) && (stop || !misaligned);

  // Cycle and retired-instruction counters, frozen in HALT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (state != S_HALT) begin
        mcycle_q <= CNT_W'(mcycle_q + 64'd1);
      end
      if (retire) begin
        minstret_q <= CNT_W'(minstret_q + 64'd1);
      end
    end
  end

  assign mcycle   = mcycle_q;
  assign minstret = minstret_q;
`else
  assign mcycle   = {CNT_W{1'b0}};
  assign minstret = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: randomized programs and memory wait
// states against an instruction-level reference model (pc, halt state, counts).
module tb_exec_sequencer;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        jump;
  logic [31:0] jump_addr;
  logic        stop;
  logic        rf_wen_req;
  logic        rf_wen;
  logic        halted;
  logic        halt_err;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  exec_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .jump       (jump),
    .jump_addr  (jump_addr),
    .stop       (stop),
    .rf_wen_req (rf_wen_req),
    .rf_wen     (rf_wen),
    .halted     (halted),
    .halt_err   (halt_err),
    .mcycle     (mcycle),
    .minstret   (minstret)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: architectural view of the core
  logic [31:0] m_pc;
  logic        m_halted;
  logic        m_herr;
  logic [63:0] m_cycle;
  logic [63:0] m_inst;

  function automatic logic [63:0] exp_cnt(input logic [63:0] v);
`ifdef SEQ_PERF_CNT_EN
    return v;
`else
    return 64'h0 & v;
`endif
  endfunction

  task automatic model_reset();
    m_pc     = RESET_PC;
    m_halted = 1'b0;
    m_herr   = 1'b0;
    m_cycle  = 64'h0;
    m_inst   = 64'h0;
  endtask

  task automatic clear_inputs();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    jump        = 1'b0;
    jump_addr   = 32'h0;
    stop        = 1'b0;
    rf_wen_req  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One instruction: `waits` stall cycles, then the response, then EXEC
  task automatic run_instr(input int waits, input logic j, input logic [31:0] ja,
                           input logic st, input logic wreq, input logic [31:0] data);
    logic [31:0] r;
    logic        mis;
    for (int w = 0; w <= waits; w++) begin
      r           = $urandom;
      imem_rvalid = (w == waits);
      imem_rdata  = (w == waits) ? data : r;
      jump        = r[0];
      stop        = r[1];
      rf_wen_req  = r[2];
      jump_addr   = r;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
        errors++;
        $display("FAIL fetch_req: req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, m_pc);
      end
      checks++;
      if (inst_valid !== 1'b0 || rf_wen !== 1'b0 || halted !== 1'b0) begin
        errors++;
        $display("FAIL fetch_quiet: inst_valid=%b rf_wen=%b halted=%b want 0 0 0", inst_valid, rf_wen, halted);
      end
      checks++;
      if (mcycle !== exp_cnt(m_cycle) || minstret !== exp_cnt(m_inst)) begin
        errors++;
        $display("FAIL fetch_cnt: mcycle=%0d minstret=%0d want %0d %0d", mcycle, minstret,
                 exp_cnt(m_cycle), exp_cnt(m_inst));
      end
      @(posedge clk);
      m_cycle++;
      @(negedge clk);
    end
    // EXEC cycle, with a stray memory response that must be ignored
    r           = $urandom;
    imem_rvalid = r[3];
    imem_rdata  = ~data;
    jump        = j;
    jump_addr   = ja;
    stop        = st;
    rf_wen_req  = wreq;
    mis         = j && (ja[1:0] != 2'b00);
    #1;
    checks++;
    if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL exec_ctrl: inst_valid=%b imem_req=%b want 1 0", inst_valid, imem_req);
    end
    checks++;
    if (inst !== data || inst_pc !== m_pc) begin
      errors++;
      $display("FAIL exec_inst: inst=%h inst_pc=%h want %h %h", inst, inst_pc, data, m_pc);
    end
    checks++;
    if (rf_wen !== (wreq && !mis)) begin
      errors++;
      $display("FAIL exec_rf_wen: got %b want %b", rf_wen, wreq && !mis);
    end
    @(posedge clk);
    m_cycle++;
    if (st) begin
      m_halted = 1'b1;
      m_inst++;
    end else if (mis) begin
      m_halted = 1'b1;
      m_herr   = 1'b1;
    end else begin
      m_pc = j ? ja : m_pc + 32'h4;
      m_inst++;
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (halted !== m_halted || halt_err !== m_herr || imem_addr !== m_pc) begin
      errors++;
      $display("FAIL post_exec: halted=%b halt_err=%b addr=%h want %b %b %h",
               halted, halt_err, imem_addr, m_halted, m_herr, m_pc);
    end
  endtask

  // Parked core must ignore every input for n cycles
  task automatic check_parked(input int n);
    logic [31:0] r;
    for (int i = 0; i < n; i++) begin
      r           = $urandom;
      imem_rvalid = r[0];
      imem_rdata  = r;
      jump        = r[1];
      jump_addr   = r;
      stop        = r[2];
      rf_wen_req  = r[3];
      #1;
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || rf_wen !== 1'b0 ||
          halted !== 1'b1 || halt_err !== m_herr || imem_addr !== m_pc) begin
        errors++;
        $display("FAIL parked: req=%b iv=%b wen=%b halted=%b err=%b addr=%h want 0 0 0 1 %b %h",
                 imem_req, inst_valid, rf_wen, halted, halt_err, imem_addr, m_herr, m_pc);
      end
      checks++;
      if (mcycle !== exp_cnt(m_cycle) || minstret !== exp_cnt(m_inst)) begin
        errors++;
        $display("FAIL parked_cnt: mcycle=%0d minstret=%0d want %0d %0d", mcycle, minstret,
                 exp_cnt(m_cycle), exp_cnt(m_inst));
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_fetch: req=%b addr=%h iv=%b want 1 %h 0", imem_req, imem_addr, inst_valid, RESET_PC);
    end
    checks++;
    if (halted !== 1'b0 || halt_err !== 1'b0 || inst !== NOP_INST || inst_pc !== RESET_PC) begin
      errors++;
      $display("FAIL reset_regs: halted=%b err=%b inst=%h inst_pc=%h", halted, halt_err, inst, inst_pc);
    end
    checks++;
    if (mcycle !== 64'h0 || minstret !== 64'h0) begin
      errors++;
      $display("FAIL reset_cnt: mcycle=%0d minstret=%0d want 0 0", mcycle, minstret);
    end
  endtask

  task automatic test_straight_line();
    do_reset();
    run_instr(0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0010_0093);
    run_instr(0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0020_0113);
    run_instr(0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0030_0193);
    checks++;
    if (imem_addr !== 32'h8000_000C) begin
      errors++;
      $display("FAIL straight_pc: got %h want 8000000c", imem_addr);
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    run_instr(3, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_0013);
    run_instr(1, 1'b0, 32'h0, 1'b0, 1'b0, 32'hBEEF_0013);
    run_instr(3, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5013);
  endtask

  task automatic test_jump();
    do_reset();
    run_instr(0, 1'b1, 32'h8000_0100, 1'b0, 1'b1, 32'h1000_006F);
    checks++;
    if (imem_addr !== 32'h8000_0100) begin
      errors++;
      $display("FAIL jump_target: got %h want 80000100", imem_addr);
    end
    run_instr(2, 1'b1, 32'h8000_0102, 1'b0, 1'b1, 32'h0020_00E7);
    check_parked(5);
  endtask

  task automatic test_wrap();
    do_reset();
    run_instr(0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_006F);
    run_instr(1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0013);
    checks++;
    if (imem_addr !== 32'h0000_0000) begin
      errors++;
      $display("FAIL pc_wrap: got %h want 00000000", imem_addr);
    end
  endtask

  task automatic test_ebreak();
    do_reset();
    run_instr(0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0010_0093);
    run_instr(0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0020_0113);
    run_instr(0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0030_0193);
    run_instr(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0010_0073);
    check_parked(20);
    checks++;
    if (mcycle !== exp_cnt(64'd8) || minstret !== exp_cnt(64'd4)) begin
      errors++;
      $display("FAIL ebreak_cnt: mcycle=%0d minstret=%0d want %0d %0d", mcycle, minstret,
               exp_cnt(64'd8), exp_cnt(64'd4));
    end
  endtask

  task automatic test_stop_and_misaligned();
    do_reset();
    run_instr(1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0013);
    run_instr(0, 1'b1, 32'h8000_0201, 1'b1, 1'b0, 32'h0010_0073);
    check_parked(3);
  endtask

  task automatic test_random_program();
    logic [31:0] r;
    logic [31:0] ja;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      r  = $urandom;
      ja = $urandom;
      ja[1:0] = 2'b00;
      run_instr(int'($urandom_range(0, 3)), (r[2:0] == 3'b000), ja, 1'b0, r[4], $urandom);
    end
    run_instr(int'($urandom_range(0, 3)), 1'b0, 32'h0, 1'b1, 1'b0, 32'h0010_0073);
    check_parked(4);
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    run_instr(0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0010_0093);
    run_instr(2, 1'b1, 32'h8000_0400, 1'b0, 1'b1, 32'h0040_006F);
    imem_rvalid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (imem_addr !== RESET_PC || imem_req !== 1'b1 || inst !== NOP_INST || inst_pc !== RESET_PC) begin
      errors++;
      $display("FAIL mid_fetch_reset: addr=%h req=%b inst=%h inst_pc=%h", imem_addr, imem_req, inst, inst_pc);
    end
    checks++;
    if (mcycle !== 64'h0 || minstret !== 64'h0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL mid_fetch_cnt: mcycle=%0d minstret=%0d halted=%b want 0 0 0", mcycle, minstret, halted);
    end
    @(negedge clk);
    rst = 1'b0;
    run_instr(0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_0013);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_straight_line();
    test_wait_states();
    test_jump();
    test_wrap();
    test_ebreak();
    test_stop_and_misaligned();
    test_random_program();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so a stuck run still ends
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within bound");
    $fatal(1);
  end

endmodule
